// File: rtl/chunk_draw_scheduler.sv
// chunk_draw_scheduler
// Demand-driven sequencer for the 16-pixel chunk drawer on a 40x30-chunk frame.
// Single-chunk redraw requests are queued in a small FIFO. Full-screen refresh
// sweeps take priority over queued requests. Each chunk is issued with a
// one-cycle draw_start, and the next chunk waits for the drawer's draw_done.
// Optional feature: define CHUNK_SCHED_DEDUP_EN to drop an in-range request
// that repeats the most recently enqueued entry still held in the FIFO.
module chunk_draw_scheduler #(
    parameter int X_CHUNKS   = 40,
    parameter int Y_CHUNKS   = 30,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_valid,
    input  logic [5:0] i_req_x_chunk,
    input  logic [4:0] i_req_y_chunk,
    output logic       o_req_ready,
    input  logic       i_refresh_start,
    output logic       o_draw_start,
    output logic [5:0] o_draw_x_chunk,
    output logic [4:0] o_draw_y_chunk,
    input  logic       i_draw_done,
    output logic       o_busy,
    output logic       o_sweep_active,
    output logic       o_bad_req
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0]       X_LIM  = 7'(X_CHUNKS);
    localparam logic [5:0]       Y_LIM  = 6'(Y_CHUNKS);
    localparam logic [5:0]       X_LAST = 6'(X_CHUNKS - 1);
    localparam logic [4:0]       Y_LAST = 5'(Y_CHUNKS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [10:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [5:0]       r_draw_x;
    logic [4:0]       r_draw_y;
    logic             r_sweep_active;
    logic             r_sweep_pending;
    logic             r_bad_req;

    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_in_range;
    logic             w_dup;
    logic             w_push;
    logic             w_pop;
    logic             w_take_sweep;
    logic             w_draw_start;
    logic             w_sweep_next;
    logic [5:0]       w_x_next;
    logic [4:0]       w_y_next;
    logic [10:0]      w_head;

    // Request admission: fullness is judged on start-of-cycle occupancy only.
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_accept   = i_req_valid & ~w_full;
    assign w_in_range = ({1'b0, i_req_x_chunk} < X_LIM) && ({1'b0, i_req_y_chunk} < Y_LIM);
    assign w_head     = r_mem[r_rd_ptr];

`ifdef CHUNK_SCHED_DEDUP_EN
    // Suppress a repeat of the newest queued entry (it is still waiting to be drawn).
    assign w_dup = ~w_empty && (r_mem[r_wr_ptr - 1'b1] == {i_req_x_chunk, i_req_y_chunk});
`else
    assign w_dup = 1'b0;
`endif

    assign w_push = w_accept & w_in_range & ~w_dup;

    // FIFO storage: contents are don't-care while the count says empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_req_x_chunk, i_req_y_chunk};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state, coordinate and sweep decisions for the IDLE/ISSUE/WAIT sequencer.
    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_draw_x;
        w_y_next     = r_draw_y;
        w_pop        = 1'b0;
        w_take_sweep = 1'b0;
        w_sweep_next = r_sweep_active;
        w_draw_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_sweep_pending) begin
                    w_take_sweep = 1'b1;
                    w_sweep_next = 1'b1;
                    w_x_next     = '0;
                    w_y_next     = '0;
                    w_state_next = S_ISSUE;
                end else if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_x_next     = w_head[10:5];
                    w_y_next     = w_head[4:0];
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_draw_start = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_draw_done) begin
                    if (r_sweep_active) begin
                        if (r_draw_x == X_LAST && r_draw_y == Y_LAST) begin
                            w_sweep_next = 1'b0;
                            w_state_next = S_IDLE;
                        end else if (r_draw_x == X_LAST) begin
                            w_x_next     = '0;
                            w_y_next     = r_draw_y + 1'b1;
                            w_state_next = S_ISSUE;
                        end else begin
                            w_x_next     = r_draw_x + 1'b1;
                            w_state_next = S_ISSUE;
                        end
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Sequencer state, coordinates, sweep flags and the bad-request pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_draw_x        <= '0;
            r_draw_y        <= '0;
            r_sweep_active  <= 1'b0;
            r_sweep_pending <= 1'b0;
            r_bad_req       <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_draw_x       <= w_x_next;
            r_draw_y       <= w_y_next;
            r_sweep_active <= w_sweep_next;
            r_bad_req      <= w_accept & ~w_in_range;
            // A new refresh pulse wins over consumption so it is never lost.
            if (i_refresh_start)   r_sweep_pending <= 1'b1;
            else if (w_take_sweep) r_sweep_pending <= 1'b0;
        end
    end

    assign o_req_ready    = ~w_full;
    assign o_draw_start   = w_draw_start;
    assign o_draw_x_chunk = r_draw_x;
    assign o_draw_y_chunk = r_draw_y;
    assign o_busy         = (r_state != S_IDLE);
    assign o_sweep_active = r_sweep_active;
    assign o_bad_req      = r_bad_req;

endmodule

// File: doc/chunk_draw_scheduler.md
# chunk_draw_scheduler

Sequences the 16-pixel chunk drawer for the 640x480 frame (40x30 chunks). It accepts redraw requests for single chunks from game logic into a small FIFO. It also runs full-screen refresh sweeps, and issues one `draw_start` per chunk to the drawer, waiting for the drawer's `draw_done` pulse before issuing the next. It sits between game/control logic and the chunk drawer/chunk memory read port, and replaces free-running chunk incrementing with demand-driven scheduling.

## Interface
- `X_CHUNKS`, 40, chunks per row; valid x is 0..X_CHUNKS-1
- `Y_CHUNKS`, 30, chunk rows; valid y is 0..Y_CHUNKS-1
- `FIFO_DEPTH`, 8, request FIFO entries; power of two, ≥2
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `req_valid`  in  1  single-chunk redraw request present
- `req_x_chunk`  in  6  requested chunk column
- `req_y_chunk`  in  5  requested chunk row
- `req_ready`  out  1  `!fifo_full`; a request is accepted on an edge where `req_valid & req_ready`
- `refresh_start`  in  1  one-cycle pulse requesting a full-screen sweep
- `draw_start`  out  1  one-cycle pulse to the drawer; coordinates are valid with it
- `draw_x_chunk`  out  6  registered chunk column to draw
- `draw_y_chunk`  out  5  registered chunk row to draw
- `draw_done`  in  1  one-cycle pulse from the drawer (pulse_flip_flop output)
- `busy`  out  1  FSM not in IDLE
- `sweep_active`  out  1  a sweep is in progress
- `bad_req`  out  1  one-cycle pulse: the accepted request was out of range and dropped

## Operation
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - If `sweep_pending`: clear the flag, set `sweep_active`, load coordinates (0,0), go to ISSUE.
  - Else, if the FIFO is non-empty: pop the head into `draw_x/y_chunk`, go to ISSUE.
  - Else stay in IDLE.
  - A pending sweep has priority over queued requests.
- **ISSUE:** `draw_start` = 1 for exactly this one cycle, then go to WAIT.
- **WAIT:** hold the coordinates. On `draw_done`:
  - **Sweep, not last chunk:** advance row-major (x increments; at x = X_CHUNKS-1, x wraps to 0 and y increments), go to ISSUE.
  - **Sweep, last chunk** (X_CHUNKS-1, Y_CHUNKS-1): clear `sweep_active`, go to IDLE.
  - **Not sweeping:** go to IDLE.
- **`draw_done` outside WAIT:** ignored.
- **`refresh_start`:**
  - Sets `sweep_pending`; at most one sweep is pending.
  - A pulse during an active sweep queues exactly one more sweep after the current one.
  - Repeated pulses while a sweep is already pending are absorbed.
- **Requests:**
  - Accepted requests are pushed during sweeps and are serviced after the sweep ends, in FIFO order.
  - When full, `req_ready` = 0 based on the occupancy at the start of the cycle. A same-cycle pop does not admit a push.
  - A request with x ≥ X_CHUNKS or y ≥ Y_CHUNKS is consumed (ready stays high) but not enqueued. `bad_req` pulses the next cycle.
- **Simultaneous events:**
  - A push and a pop in the same cycle on a non-full FIFO: both occur and the count is unchanged.
  - `refresh_start` and `draw_done` in the same cycle: both take effect.

## Timing
- **Reset values:**
  - `draw_start`, `busy`, `sweep_active`, `bad_req` = 0.
  - `draw_x_chunk` = `draw_y_chunk` = 0.
  - `req_ready` = 1.
  - FIFO empty, `sweep_pending` = 0, state IDLE.
- **Request latency:**
  - Request accepted at edge E0.
  - Pop and coordinate latch at E1.
  - `draw_start` is high from E1 to E2.
  - Idle-to-start latency is 2 edges.
- **Sweep cadence:** the edge sampling `draw_done` loads the next coordinates and enters ISSUE. `draw_start` is high the following cycle.
- **Coordinate stability:** `draw_x/y_chunk` change only on entry to ISSUE.
- **Reset mid-operation:**
  - Immediate return to the reset values.
  - The FIFO and the pending sweep are discarded.
  - The drawer is reset by its own reset; a later stray `draw_done` is ignored.

## Configuration
- **`CHUNK_SCHED_DEDUP_EN` defined:** an in-range request whose (x,y) equals the most recently enqueued entry still present in the FIFO is consumed without a push. `bad_req` does not pulse.
- **Not defined:** every in-range accepted request is enqueued, duplicates included.

## Test plan
- **Single request:** reset, then request (5,3). Required:
  - `draw_start` exactly one cycle, 2 edges after acceptance, with coords (5,3), `busy` = 1.
  - `draw_done` returns the FSM to IDLE, `busy` = 0.
- **FIFO full:** hold `draw_done` low, push 1+FIFO_DEPTH distinct requests. Required:
  - The first is issued, 8 are queued, and `req_ready` = 0 once 8 are queued.
  - Further `req_valid` is ignored.
  - Drain order matches push order.
- **Full sweep:** `refresh_start`, with `draw_done` returned 3 cycles after each `draw_start`. Required:
  - Exactly 1200 `draw_start` pulses.
  - First (0,0), second (1,0), 41st (0,1), last (39,29).
  - `sweep_active` falls after the last done.
- **Priority:** queue (2,2) while the drawer is busy with (7,7), and pulse `refresh_start`. Required: after (7,7) completes, the sweep runs first and (2,2) is issued after (39,29).
- **Bad request and dedup:**
  - Request (40,0). Required: `bad_req` pulses once, no draw.
  - With `CHUNK_SCHED_DEDUP_EN`, push (4,4) twice while stalled. Required: only one (4,4) is drawn. Without the macro, two are drawn.
- **Reset mid-sweep:** assert `reset` at chunk (10,2). Required:
  - All outputs return to their reset values immediately.
  - No further `draw_start` until a new request arrives.
